// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core priority, bounded external wait, locked bursts.
// Optional stall statistics counter enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wd,
   output logic [DATA_W-1:0] cpu_rd,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic              ext_lock,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wd,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {S_CPU, S_BURST} state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic [BW-1:0] burst_cnt;
   logic          wait_full;
   logic          burst_last;

   assign wait_full  = (wait_cnt == WW'(MAX_WAIT));
   // burst_cnt grants are done; the one in this cycle closes the run at MAX_BURST
   assign burst_last = ((int'(burst_cnt) + 1) >= MAX_BURST);

   always_comb begin
      ext_gnt = ext_req &&
                ((state == S_BURST) || !cpu_req || wait_full);
   end

   assign cpu_stall = cpu_req && ext_gnt;
   assign cpu_rd    = mem_rd;

   always_comb begin
      if (ext_gnt) begin
         mem_we   = ext_we && !rst;
         mem_addr = ext_addr;
         mem_wd   = ext_wd;
      end else begin
         mem_we   = cpu_req && cpu_we && !rst;
         mem_addr = cpu_addr;
         mem_wd   = cpu_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_CPU;
         wait_cnt   <= '0;
         burst_cnt  <= '0;
         ext_rvalid <= 1'b0;
         ext_rdata  <= '0;
      end else begin
         ext_rvalid <= ext_gnt && !ext_we;
         if (ext_gnt && !ext_we)
            ext_rdata <= mem_rd;

         if (ext_gnt || !ext_req)
            wait_cnt <= '0;
         else if (!wait_full)
            wait_cnt <= wait_cnt + WW'(1);

         case (state)
            S_CPU: begin
               if (ext_gnt && ext_lock && (MAX_BURST > 1)) begin
                  state     <= S_BURST;
                  burst_cnt <= BW'(1);
               end
            end
            S_BURST: begin
               if (ext_req && ext_lock && !burst_last) begin
                  burst_cnt <= burst_cnt + BW'(1);
               end else begin
                  state     <= S_CPU;
                  burst_cnt <= '0;
                  wait_cnt  <= '0;
               end
            end
            default: begin
               state     <= S_CPU;
               burst_cnt <= '0;
            end
         endcase
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || stats_clr)
         stall_cycles <= '0;
      else if (cpu_stall && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: cycle model plus directed scenarios.
// Build with DMEM_ARB_STATS_EN defined to also cover the stall counter.
module tb_dmem_arbiter;

   localparam int MW = 4;
   localparam int MB = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wd = '0;
   logic [31:0] cpu_rd;
   logic        cpu_stall;
   logic        ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
   logic [31:0] ext_addr = '0, ext_wd = '0;
   logic        ext_gnt, ext_rvalid;
   logic [31:0] ext_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
   logic        stats_clr = 1'b0;
   logic [31:0] stall_cycles;
`endif

   logic [31:0] mem [0:255] = '{default: '0};

   assign mem_rd = mem[mem_addr[7:0]];

   always @(posedge clk)
      if (mem_we) mem[mem_addr[7:0]] <= mem_wd;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
      .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
      .ext_addr(ext_addr), .ext_wd(ext_wd),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
      .ext_rdata(ext_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
      , .stats_clr(stats_clr), .stall_cycles(stall_cycles)
`endif
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Model: counts denied cycles and locked grants in the current run
   int          denied = 0;
   int          run = 0;
   bit          in_burst = 0;
   logic        exp_rvalid = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic [31:0] shadow [0:255] = '{default: '0};
   logic        m_g, m_we;
   logic [31:0] m_a, m_d;

   always @(negedge clk) begin
      m_g  = ext_req && (in_burst || !cpu_req || denied == MW);
      m_a  = m_g ? ext_addr : cpu_addr;
      m_d  = m_g ? ext_wd : cpu_wd;
      m_we = !rst && (m_g ? ext_we : (cpu_req && cpu_we));
      chk("ext_gnt", 32'(ext_gnt), 32'(m_g));
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && m_g));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", mem_addr, m_a);
      chk("mem_wd", mem_wd, m_d);
      chk("cpu_rd", cpu_rd, shadow[m_a[7:0]]);
      chk("ext_rvalid", 32'(ext_rvalid), 32'(exp_rvalid));
      chk("ext_rdata", ext_rdata, exp_rdata);
      if (rst) begin
         denied = 0;
         run = 0;
         in_burst = 0;
         exp_rvalid = 1'b0;
         exp_rdata = '0;
      end else begin
         exp_rvalid = m_g && !ext_we;
         if (m_g && !ext_we) exp_rdata = shadow[m_a[7:0]];
         if (m_we) shadow[m_a[7:0]] = m_d;
         denied = (m_g || !ext_req) ? 0 :
                  (denied < MW ? denied + 1 : MW);
         if (m_g && ext_lock) run++;
         else run = 0;
         in_burst = m_g && ext_lock && (run < MB);
         if (!in_burst) run = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset, with a core store attempted during reset
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 32'h40; cpu_wd = 32'h5555_5555;
      tick();
      #1;
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_rvalid", 32'(ext_rvalid), 32'h0);
      chk("rst_rdata", ext_rdata, 32'h0);
`ifdef DMEM_ARB_STATS_EN
      chk("rst_stall_cycles", stall_cycles, 32'h0);
`endif
      tick();

      // core store then load of 0x10
      rst = 1'b0;
      cpu_addr = 32'h10; cpu_wd = 32'hDEAD_BEEF;
      #1;
      chk("core_st_we", 32'(mem_we), 32'h1);
      chk("core_st_stall", 32'(cpu_stall), 32'h0);
      tick();
      cpu_we = 1'b0;
      #1;
      chk("core_ld_we", 32'(mem_we), 32'h0);
      chk("core_ld_rd", cpu_rd, 32'hDEAD_BEEF);
      tick();

      // idle core: external write then read of 0x20
      cpu_req = 1'b0;
      ext_req = 1'b1; ext_we = 1'b1;
      ext_addr = 32'h20; ext_wd = 32'h1234_5678;
      #1;
      chk("ext_wr_gnt", 32'(ext_gnt), 32'h1);
      tick();
      ext_we = 1'b0;
      #1;
      chk("ext_rd_gnt", 32'(ext_gnt), 32'h1);
      tick();
      ext_req = 1'b0;
      #1;
      chk("ext_rd_valid", 32'(ext_rvalid), 32'h1);
      chk("ext_rd_data", ext_rdata, 32'h1234_5678);
      tick();
      chk("ext_rd_done", 32'(ext_rvalid), 32'h0);
      chk("ext_rd_hold", ext_rdata, 32'h1234_5678);

      // starvation: both request every cycle
      cpu_req = 1'b1; cpu_addr = 32'h10;
      ext_req = 1'b1;
      for (int i = 0; i < 15; i++) begin
         #1;
         chk($sformatf("starve_gnt%0d", i), 32'(ext_gnt),
             32'((i % 5) == 4));
         chk($sformatf("starve_stall%0d", i), 32'(cpu_stall),
             32'((i % 5) == 4));
         tick();
      end
`ifdef DMEM_ARB_STATS_EN
      chk("stall_cycles", stall_cycles, 32'd3);
`endif
      ext_req = 1'b0; cpu_req = 1'b0;
`ifdef DMEM_ARB_STATS_EN
      stats_clr = 1'b1;
`endif
      tick();
`ifdef DMEM_ARB_STATS_EN
      stats_clr = 1'b0;
      chk("stats_clr", stall_cycles, 32'h0);
`endif

      // burst limit with core contending
      cpu_req = 1'b1;
      ext_req = 1'b1; ext_lock = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk($sformatf("burst_gnt%0d", i), 32'(ext_gnt),
             32'(i >= 4 && i < 12));
         if (i == 12)
            chk("burst_release", 32'(cpu_stall), 32'h0);
         tick();
      end
      ext_req = 1'b0; ext_lock = 1'b0; cpu_req = 1'b0;
      tick();

      // reset in the third burst cycle
      ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("rb_gnt%0d", i), 32'(ext_gnt), 32'h1);
         tick();
      end
      rst = 1'b1;
      tick();
      chk("rb_rvalid", 32'(ext_rvalid), 32'h0);
      ext_we = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
      #1;
      chk("rb_mem_we", 32'(mem_we), 32'h0);
      tick();
      rst = 1'b0;
      ext_we = 1'b0; ext_lock = 1'b0; cpu_we = 1'b0;
      #1;
      chk("rb_core_wins", 32'(ext_gnt), 32'h0);
      tick();
      ext_req = 1'b0; cpu_req = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory port between the core (load/store path) and an external master (debug port, program loader, DMA).
- Sits between the core's data-memory signals and the data memory.
- The core keeps priority by default. The external master is guaranteed service within MAX_WAIT cycles and may lock the port for short bursts.
- The core holds its PC and register write while cpu_stall is high.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, maximum consecutive cycles ext_req may be denied before a forced external grant (>=1).
- MAX_BURST, 8, maximum consecutive locked external grants (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  core needs memory this cycle (load or store).
- cpu_we  in  1  core store.
- cpu_addr  in  ADDR_W  core address.
- cpu_wd  in  DATA_W  core store data.
- cpu_rd  out  DATA_W  combinational read data to core (mem_rd passthrough).
- cpu_stall  out  1  core must not commit this cycle.
- ext_req  in  1  external master request.
- ext_we  in  1  external write.
- ext_lock  in  1  request to hold grant next cycle (burst).
- ext_addr  in  ADDR_W  external address.
- ext_wd  in  DATA_W  external write data.
- ext_gnt  out  1  external access performed this cycle.
- ext_rvalid  out  1  registered read data valid.
- ext_rdata  out  DATA_W  registered read data.
- mem_we  out  1  to data memory write enable.
- mem_addr  out  ADDR_W  to data memory address.
- mem_wd  out  DATA_W  to data memory write data.
- mem_rd  in  DATA_W  from data memory, combinational read.

Behaviour:
- States: S_CPU (default), S_BURST (external holds lock).
- Internal counters: wait_cnt (0..MAX_WAIT, saturating) and burst_cnt (0..MAX_BURST).
- ext_gnt (combinational):
  - In S_CPU: ext_req && (!cpu_req || wait_cnt == MAX_WAIT).
  - In S_BURST: ext_req.
- cpu_stall = cpu_req && ext_gnt. The core is never stalled when ext_gnt is 0.
- Memory mux:
  - When ext_gnt: mem_we = ext_we, mem_addr = ext_addr, mem_wd = ext_wd.
  - Otherwise: mem_we = cpu_req && cpu_we && !rst, mem_addr = cpu_addr, mem_wd = cpu_wd.
  - cpu_rd = mem_rd always.
  - mem_we is forced 0 while rst is high.
- wait_cnt:
  - Reset to 0 when ext_gnt or !ext_req.
  - Otherwise increments, saturating at MAX_WAIT.
- Transitions:
  - S_CPU -> S_BURST when ext_gnt && ext_lock && ext_req; burst_cnt <= 1.
  - S_BURST stays while ext_req && ext_lock && burst_cnt < MAX_BURST; burst_cnt increments.
  - S_BURST -> S_CPU when !ext_req, !ext_lock, or burst_cnt == MAX_BURST. wait_cnt <= 0 on this exit.
  - After a burst-limit exit, the external master is next granted in S_CPU only by the normal rule, so the core regains the port for at least one cycle if cpu_req.
- Read return:
  - ext_rvalid <= ext_gnt && !ext_we.
  - ext_rdata <= mem_rd captured in the granted cycle (latency 1).
  - ext_rdata holds its value when ext_rvalid is 0.
- Simultaneous cpu_req and ext_req with wait_cnt < MAX_WAIT: core wins, ext waits.
- ext_req dropped mid-burst: exit to S_CPU next edge; no grant that cycle.
- Reset values: state S_CPU, wait_cnt 0, burst_cnt 0, ext_rvalid 0, ext_rdata 0.
- Reset mid-burst: the burst is abandoned at the reset edge; any pending read is not returned.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined: adds output stall_cycles [31:0] and input stats_clr [1].
  - stall_cycles increments each cycle cpu_stall is 1, saturating at 0xFFFFFFFF.
  - Cleared by rst or stats_clr. stats_clr has priority over the increment.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Core only: cpu_req=1, cpu_we=1, addr 0x10, wd 0xDEADBEEF; then a read of 0x10 -> mem_we=1 for one cycle, cpu_stall=0, cpu_rd=0xDEADBEEF next cycle.
- Idle core: ext read of 0x20 (preloaded 0x12345678) with cpu_req=0 -> ext_gnt=1 same cycle, ext_rvalid=1 and ext_rdata=0x12345678 one cycle later.
- Starvation: cpu_req and ext_req held high continuously, MAX_WAIT=4 -> ext_gnt low 4 cycles, high on the 5th with cpu_stall=1, then low for 4 again.
- Burst limit: ext_lock=1, ext_req=1, cpu_req=1, MAX_BURST=8 -> ext_gnt high 8 consecutive cycles once granted, then cpu_stall=0 for at least 1 cycle.
- Reset mid-burst: rst asserted in 3rd burst cycle -> next cycle state S_CPU, ext_rvalid=0, mem_we=0 during rst.
- With DMEM_ARB_STATS_EN: after the starvation scenario runs 15 cycles -> stall_cycles=3; pulse stats_clr -> 0 next cycle.
